// File: rtl/pc_fetch_unit_if.sv
// Bus between the instruction decoder / program memory side and the fetch unit.
// The master side issues decoder strobes and supplies program memory data.
// The slave side (the fetch unit) returns the fetch address, the instruction
// register and the stack status flags.
interface pc_fetch_unit_if #(
   parameter int PC_WIDTH = 13
);
   logic                pc_incr_en;
   logic                pc_j_en;
   logic                pc_j_and_push_en;
   logic                pc_j_by_pop_en;
   logic                instr_rd_en;
   logic                instr_flush;
   logic [4:0]          pclath;
   logic                pcl_wr_en;
   logic [7:0]          pcl_wr_data;
   logic [13:0]         prog_rdata;
   logic [PC_WIDTH-1:0] prog_addr;
   logic [13:0]         instr_current;
   logic [PC_WIDTH-1:0] pc;
   logic                stack_ovf;
   logic                stack_unf;

   modport master (
      output pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en,
      output instr_rd_en, instr_flush, pclath, pcl_wr_en, pcl_wr_data,
      output prog_rdata,
      input  prog_addr, instr_current, pc, stack_ovf, stack_unf
   );

   modport slave (
      input  pc_incr_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en,
      input  instr_rd_en, instr_flush, pclath, pcl_wr_en, pcl_wr_data,
      input  prog_rdata,
      output prog_addr, instr_current, pc, stack_ovf, stack_unf
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, circular hardware return stack and instruction register
// for the PIC16F-compatible core. The decoder drives one-cycle strobes; the PC
// update follows a fixed priority (PCL write, return, call, goto, increment),
// while the instruction register update is independent of the PC strobes.
// A PCL write leaves a pending flag so that the following fetch slot is
// squashed into a NOP and the PC is held for one increment, giving the
// two-cycle computed goto.
// STACK_DEPTH must be a power of two so the stack pointer wraps naturally.
module pc_fetch_unit #(
   parameter int          PC_WIDTH    = 13,
   parameter int          STACK_DEPTH = 8,
   parameter logic [13:0] NOP_WORD    = 14'h0000
) (
   input logic              clk,
   input logic              rst,
   pc_fetch_unit_if.slave   bus
);

   localparam int              SP_W       = $clog2(STACK_DEPTH);
   localparam logic [SP_W:0]   DEPTH_FULL = (SP_W+1)'(STACK_DEPTH);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [13:0]         instr_q, instr_d;
   logic [SP_W-1:0]     sp_q, sp_d;
   logic [SP_W:0]       depth_q, depth_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                pclPending_q, pclPending_d;

   logic [PC_WIDTH-1:0] stackMem [STACK_DEPTH];
   logic [SP_W-1:0]     spDec;
   logic                pushEn;
   logic [PC_WIDTH-1:0] jumpTarget;

   assign spDec      = sp_q - SP_W'(1);
   assign jumpTarget = PC_WIDTH'({bus.pclath[4:3], instr_q[10:0]});

   // Next-state logic: prioritised PC/stack update plus the independent
   // instruction register update. Jump targets and the pushed return address
   // always come from the pre-edge register values.
   always_comb begin
      pc_d         = pc_q;
      instr_d      = instr_q;
      sp_d         = sp_q;
      depth_d      = depth_q;
      ovf_d        = ovf_q;
      unf_d        = unf_q;
      pclPending_d = pclPending_q;
      pushEn       = 1'b0;

      if (bus.pcl_wr_en) begin
         pc_d         = PC_WIDTH'({bus.pclath, bus.pcl_wr_data});
         pclPending_d = 1'b1;
      end else if (bus.pc_j_by_pop_en) begin
         sp_d = spDec;
         pc_d = stackMem[spDec];
         if (depth_q == '0) begin
            unf_d = 1'b1;
         end else begin
            depth_d = depth_q - 1'b1;
         end
      end else if (bus.pc_j_and_push_en) begin
         pushEn = 1'b1;
         sp_d   = sp_q + SP_W'(1);
         pc_d   = jumpTarget;
         if (depth_q == DEPTH_FULL) begin
            ovf_d = 1'b1;
         end else begin
            depth_d = depth_q + 1'b1;
         end
      end else if (bus.pc_j_en) begin
         pc_d = jumpTarget;
      end else if (bus.pc_incr_en) begin
         if (pclPending_q) begin
            pclPending_d = 1'b0;
         end else begin
            pc_d = pc_q + PC_WIDTH'(1);
         end
      end

      if (bus.instr_flush || (bus.instr_rd_en && pclPending_q)) begin
         instr_d = NOP_WORD;
      end else if (bus.instr_rd_en) begin
         instr_d = bus.prog_rdata;
      end
   end

   // State registers with asynchronous reset; the stack RAM is kept apart
   // because its contents are deliberately left uninitialised.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= '0;
         instr_q      <= NOP_WORD;
         sp_q         <= '0;
         depth_q      <= '0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         pclPending_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         sp_q         <= sp_d;
         depth_q      <= depth_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
         pclPending_q <= pclPending_d;
      end
   end

   // Return stack storage: a push writes the pre-edge PC (the address after
   // the CALL) at the current stack pointer; nothing is written during reset.
   always_ff @(posedge clk) begin
      if (pushEn && !rst) begin
         stackMem[sp_q] <= pc_q;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.prog_addr     = pc_q;
   assign bus.instr_current = instr_q;
   assign bus.stack_ovf     = ovf_q;
   assign bus.stack_unf     = unf_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by a
// randomised strobe stream. A reference model computes the expected state
// after every edge and pushes it onto a scoreboard queue; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_pc_fetch_unit;

   localparam logic [13:0] NOP = 14'h0000;

   typedef struct {
      logic [12:0] pc;
      logic [13:0] instr;
      logic        ovf;
      logic        unf;
   } expect_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pc_fetch_unit_if #(.PC_WIDTH(13)) busIf ();

   pc_fetch_unit #(
      .PC_WIDTH(13),
      .STACK_DEPTH(8),
      .NOP_WORD(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(busIf)
   );

   logic [13:0] mem [8192];
   expect_t     expQ [$];
   expect_t     monE;

   int          mPc;
   logic [13:0] mInstr;
   int          mStack [8];
   int          mSp;
   int          mDepth;
   logic        mOvf;
   logic        mUnf;
   logic        mPend;

   int          retAddr [9];

   assign busIf.prog_rdata = mem[busIf.prog_addr];

   // Free-running core clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one DUT output against a required value and counts it.
   task automatic checkValue(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   // Compares the full observable state against one expected record.
   task automatic checkOutput(input expect_t e, input string tag);
      checkValue({tag, " pc"}, int'(busIf.pc), int'(e.pc));
      checkValue({tag, " prog_addr"}, int'(busIf.prog_addr), int'(e.pc));
      checkValue({tag, " instr_current"}, int'(busIf.instr_current), int'(e.instr));
      checkValue({tag, " stack_ovf"}, int'(busIf.stack_ovf), int'(e.ovf));
      checkValue({tag, " stack_unf"}, int'(busIf.stack_unf), int'(e.unf));
   endtask

   // Model reset; the stack contents are not touched, like the hardware.
   task automatic modelReset();
      mPc    = 0;
      mInstr = NOP;
      mSp    = 0;
      mDepth = 0;
      mOvf   = 1'b0;
      mUnf   = 1'b0;
      mPend  = 1'b0;
   endtask

   task automatic clearStrobes();
      busIf.pc_incr_en       = 1'b0;
      busIf.pc_j_en          = 1'b0;
      busIf.pc_j_and_push_en = 1'b0;
      busIf.pc_j_by_pop_en   = 1'b0;
      busIf.instr_rd_en      = 1'b0;
      busIf.instr_flush      = 1'b0;
      busIf.pcl_wr_en        = 1'b0;
   endtask

   // Drives one clock cycle of strobes, advances the reference model and
   // pushes the expected post-edge state onto the scoreboard.
   task automatic applyStimulus(input logic incr, input logic jmp, input logic push,
                                input logic pop, input logic rd, input logic flush,
                                input logic pclWr, input logic [4:0] lath,
                                input logic [7:0] data);
      int          nPc;
      int          target;
      logic [13:0] nInstr;
      logic        nPend;
      expect_t     e;
      @(negedge clk);
      #1;
      busIf.pc_incr_en       = incr;
      busIf.pc_j_en          = jmp;
      busIf.pc_j_and_push_en = push;
      busIf.pc_j_by_pop_en   = pop;
      busIf.instr_rd_en      = rd;
      busIf.instr_flush      = flush;
      busIf.pcl_wr_en        = pclWr;
      busIf.pclath           = lath;
      busIf.pcl_wr_data      = data;

      target = ((int'(lath) >> 3) & 3) * 2048 + (int'(mInstr) & 2047);
      nPc    = mPc;
      nInstr = mInstr;
      nPend  = mPend;
      if (pclWr) begin
         nPc   = int'(lath) * 256 + int'(data);
         nPend = 1'b1;
      end else if (pop) begin
         mSp = (mSp + 7) % 8;
         nPc = mStack[mSp];
         if (mDepth == 0) mUnf = 1'b1;
         else mDepth--;
      end else if (push) begin
         mStack[mSp] = mPc;
         mSp = (mSp + 1) % 8;
         if (mDepth == 8) mOvf = 1'b1;
         else mDepth++;
         nPc = target;
      end else if (jmp) begin
         nPc = target;
      end else if (incr) begin
         if (mPend) nPend = 1'b0;
         else nPc = (mPc + 1) % 8192;
      end
      if (flush || (rd && mPend)) nInstr = NOP;
      else if (rd) nInstr = mem[mPc];
      mPc    = nPc;
      mInstr = nInstr;
      mPend  = nPend;

      @(posedge clk);
      #1;
      clearStrobes();
      e.pc    = 13'(mPc);
      e.instr = mInstr;
      e.ovf   = mOvf;
      e.unf   = mUnf;
      expQ.push_back(e);
   endtask

   // Scoreboard monitor: compares each expected record on the falling edge.
   always @(negedge clk) begin
      if (!rst && expQ.size() > 0) begin
         monE = expQ.pop_front();
         checkOutput(monE, "scoreboard");
      end
   end

   initial begin
      expect_t rstE;
      logic    r1, r2, r3, r4, r5, r6, r7;
      int      sel;
      total = 0;
      bad   = 0;
      rstE.pc    = '0;
      rstE.instr = NOP;
      rstE.ovf   = 1'b0;
      rstE.unf   = 1'b0;
      for (int i = 0; i < 8192; i++) mem[i] = 14'($urandom);
      mem[4]     = 14'h2923;
      mem[15]    = 14'h2050;
      mem[16'h50] = 14'h0008;
      for (int i = 0; i < 8; i++) mStack[i] = 0;
      clearStrobes();
      busIf.pclath      = '0;
      busIf.pcl_wr_data = '0;
      modelReset();

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput(rstE, "reset");
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] sequential fetch, 4 clocks per instruction");
      for (int k = 0; k < 4; k++) begin
         repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0, 8'd0);
         applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
         if (k == 0) begin
            checkValue("first fetch pc", int'(busIf.pc), 1);
            checkValue("first fetch instr", int'(busIf.instr_current), int'(mem[0]));
         end
      end
      checkValue("pc after 16 clocks", int'(busIf.pc), 4);

      $display("[TB] GOTO with PCLATH");
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 5'b01000, 8'd0);
      checkValue("goto pc", int'(busIf.pc), 'h0923);
      checkValue("goto flush", int'(busIf.instr_current), 0);

      $display("[TB] CALL then RETURN");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd0, 8'h0F);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
      checkValue("call fetch pc", int'(busIf.pc), 'h010);
      applyStimulus(0, 0, 1, 0, 0, 1, 0, 5'd0, 8'd0);
      checkValue("call pc", int'(busIf.pc), 'h050);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 5'd0, 8'd0);
      checkValue("return pc", int'(busIf.pc), 'h010);
      checkValue("return no unf", int'(busIf.stack_unf), 0);

      $display("[TB] nine nested CALLs and nine RETURNs");
      for (int i = 0; i < 9; i++) begin
         mem[mPc] = 14'(14'h2000 + 'h100 + 16 * i);
         applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
         retAddr[i] = mPc;
         applyStimulus(0, 0, 1, 0, 0, 1, 0, 5'd0, 8'd0);
         if (i == 7) checkValue("ovf after 8 pushes", int'(busIf.stack_ovf), 0);
      end
      checkValue("ovf after 9 pushes", int'(busIf.stack_ovf), 1);
      for (int j = 0; j < 9; j++) begin
         applyStimulus(0, 0, 0, 1, 0, 1, 0, 5'd0, 8'd0);
         if (j < 8) begin
            checkValue("nested return pc", int'(busIf.pc), retAddr[8 - j]);
            checkValue("unf before 9th pop", int'(busIf.stack_unf), 0);
         end
      end
      checkValue("unf after 9th pop", int'(busIf.stack_unf), 1);

      $display("[TB] computed goto via PCL");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'h02, 8'h40);
      checkValue("pcl pc", int'(busIf.pc), 'h240);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'h02, 8'd0);
      checkValue("pcl held pc", int'(busIf.pc), 'h240);
      checkValue("pcl squashed instr", int'(busIf.instr_current), 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'h02, 8'd0);
      checkValue("pcl target fetch", int'(busIf.instr_current), int'(mem['h240]));
      checkValue("pcl next pc", int'(busIf.pc), 'h241);

      $display("[TB] randomised strobe stream");
      for (int n = 0; n < 400; n++) begin
         {r1, r2, r3, r4, r5, r6, r7} = '0;
         sel = $urandom_range(0, 11);
         case (sel)
            0:       r7 = 1'b1;
            1:       r4 = 1'b1;
            2:       r3 = 1'b1;
            3:       r2 = 1'b1;
            4, 5:    ;
            default: r1 = 1'b1;
         endcase
         if ($urandom_range(0, 9) == 0) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) r2 = 1'b1;
            else if (sel == 1) r3 = 1'b1;
            else if (sel == 2) r4 = 1'b1;
            else r1 = 1'b1;
         end
         r5 = 1'($urandom_range(0, 1));
         r6 = ($urandom_range(0, 3) == 0);
         applyStimulus(r1, r2, r3, r4, r5, r6, r7, 5'($urandom), 8'($urandom));
      end

      $display("[TB] asynchronous reset in the middle of a CALL");
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 5'd0, 8'd0);
      applyStimulus(0, 0, 1, 0, 0, 1, 0, 5'd0, 8'd0);
      @(negedge clk);
      #1;
      busIf.pc_j_and_push_en = 1'b1;
      busIf.instr_flush      = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checkOutput(rstE, "async reset");
      modelReset();
      expQ.delete();
      @(posedge clk);
      #1;
      clearStrobes();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd0, 8'd0);
      checkValue("post-reset fetch", int'(busIf.instr_current), int'(mem[0]));
      checkValue("post-reset pc", int'(busIf.pc), 1);

      repeat (2) @(negedge clk);
      #1;
      checkValue("scoreboard drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
